// File: rtl/display_buf_scanner.sv
// Raster reader: streams the 160x80 frame region of the display buffer RAM to the
// LCD transmitter. Optional RGB332->RGB565 expansion under DISP_SCAN_RGB565_EN.
module display_buf_scanner #(
  parameter int LEN   = 12800,
  parameter int WIDTH = 8,
  parameter int X_MAX = 160,
  parameter int Y_MAX = 80,
  parameter int BASE  = 0,
  localparam int AW   = $clog2(LEN),
`ifdef DISP_SCAN_RGB565_EN
  localparam int PW   = 16
`else
  localparam int PW   = WIDTH
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             frame_done,
  output logic             buf_req,
  output logic [AW-1:0]    addr,
  output logic             rd_en,
  input  logic [WIDTH-1:0] dout,
  output logic [PW-1:0]    pix_data,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic             pix_last,
  output logic [1:0]       dbg_state
);

  localparam int TOTAL = X_MAX * Y_MAX;
  localparam int CW    = $clog2(TOTAL + 1);
  localparam logic [CW-1:0] TOTAL_C  = CW'(TOTAL);
  localparam logic [CW-1:0] LAST_IDX = CW'(TOTAL - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    rd_ptr;
  logic [CW-1:0]    dcnt;
  logic [WIDTH-1:0] fifo_mem [4];
  logic [1:0]       wptr;
  logic [1:0]       rptr;
  logic [2:0]       count;
  logic             ret_p1;
  logic             ret_p2;
  logic [WIDTH-1:0] head_q;

  logic             pop;
  logic             push;
  logic [2:0]       remain;
  logic [2:0]       count_n;
  logic [2:0]       pending_n;
  logic [1:0]       rptr_n;
  logic [CW-1:0]    dcnt_n;
  logic             issue_ok;
  logic [WIDTH-1:0] head_n;

  // Handshake: a pixel transfers on every rising edge where pix_valid & pix_ready;
  // once raised, pix_valid and pix_data hold until that transfer happens.
  always_comb begin
    pop       = pix_valid & pix_ready;
    push      = ret_p2;
    remain    = count - {2'b00, pop};
    count_n   = remain + {2'b00, push};
    rptr_n    = rptr + {1'b0, pop};
    dcnt_n    = dcnt + {{(CW-1){1'b0}}, pop};
    // Reserve FIFO space for every read still travelling through the RAM pipeline.
    pending_n = count_n + {2'b00, rd_en} + {2'b00, ret_p1};
    issue_ok  = (rd_ptr < TOTAL_C) && (pending_n < 3'd4);
    head_n    = (remain == 3'd0) ? dout : fifo_mem[rptr_n];
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wptr] <= dout;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      buf_req    <= 1'b0;
      addr       <= '0;
      rd_en      <= 1'b0;
      rd_ptr     <= '0;
      dcnt       <= '0;
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      ret_p1     <= 1'b0;
      ret_p2     <= 1'b0;
      head_q     <= '0;
      pix_valid  <= 1'b0;
      pix_last   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      rd_en      <= 1'b0;
      ret_p1     <= rd_en;
      ret_p2     <= ret_p1;
      wptr       <= wptr + {1'b0, push};
      rptr       <= rptr_n;
      count      <= count_n;
      dcnt       <= dcnt_n;
      head_q     <= head_n;
      pix_valid  <= (count_n != 3'd0);
      pix_last   <= (count_n != 3'd0) && (dcnt_n == LAST_IDX);
      case (state)
        IDLE: begin
          if (start) begin
            state     <= (TOTAL == 1) ? DRAIN : SCAN;
            busy      <= 1'b1;
            buf_req   <= 1'b1;
            rd_en     <= 1'b1;
            addr      <= AW'(BASE);
            rd_ptr    <= CW'(1);
            dcnt      <= '0;
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            pix_valid <= 1'b0;
            pix_last  <= 1'b0;
          end
        end
        SCAN: begin
          if (issue_ok) begin
            rd_en  <= 1'b1;
            addr   <= AW'(BASE) + AW'(rd_ptr);
            rd_ptr <= rd_ptr + CW'(1);
            if (rd_ptr == LAST_IDX) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (dcnt_n == TOTAL_C) begin
            state      <= IDLE;
            busy       <= 1'b0;
            buf_req    <= 1'b0;
            frame_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign dbg_state = state;

`ifdef DISP_SCAN_RGB565_EN
  // Replicate the high bits of each RGB332 field to fill the wider RGB565 field.
  assign pix_data = {head_q[7:5], head_q[7:6], head_q[4:2], head_q[4:2],
                     head_q[1:0], head_q[1:0], head_q[1]};
`else
  assign pix_data = head_q;
`endif

endmodule

// File: tb/tb_display_buf_scanner.sv
// Bench for display_buf_scanner: RAM model with 2-cycle read latency, frame scoreboard
// built from RAM contents, randomized pix_ready, mid-frame start and reset.
module tb_display_buf_scanner;

  localparam int LEN   = 12800;
  localparam int WIDTH = 8;
  localparam int X_MAX = 160;
  localparam int Y_MAX = 80;
  localparam int BASE  = 0;
  localparam int TOTAL = X_MAX * Y_MAX;
  localparam int AW    = $clog2(LEN);
`ifdef DISP_SCAN_RGB565_EN
  localparam int PW = 16;
  localparam logic [31:0] EXP_E3 = 32'hF81F;
  localparam logic [31:0] EXP_1C = 32'h07E0;
`else
  localparam int PW = WIDTH;
  localparam logic [31:0] EXP_E3 = 32'hE3;
  localparam logic [31:0] EXP_1C = 32'h1C;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             busy;
  logic             frame_done;
  logic             buf_req;
  logic [AW-1:0]    addr;
  logic             rd_en;
  logic [WIDTH-1:0] dout = '0;
  logic [PW-1:0]    pix_data;
  logic             pix_valid;
  logic             pix_ready = 1'b0;
  logic             pix_last;
  logic [1:0]       dbg_state;

  display_buf_scanner dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .frame_done(frame_done),
    .buf_req(buf_req), .addr(addr), .rd_en(rd_en), .dout(dout),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_last(pix_last), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: data appears two cycles after the rd_en cycle
  logic [WIDTH-1:0] ram [LEN];
  logic [WIDTH-1:0] ram_s1 = '0;
  always @(posedge clk) begin
    if (rd_en) ram_s1 <= ram[addr];
    dout <= ram_s1;
  end

  // scoreboard state
  logic [PW-1:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  int frame_active = 0;
  int pix_cnt, reads_issued, start_cyc, first_rd_cyc, first_valid_cyc, done_cyc, last_cnt;
  logic prev_stall = 1'b0;
  logic [PW-1:0] prev_data = '0;
  int ready_mode = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] expand(input logic [7:0] p);
`ifdef DISP_SCAN_RGB565_EN
    int r, g, b, r5, g6, b5;
    r = int'(p) / 32;
    g = (int'(p) / 4) % 8;
    b = int'(p) % 4;
    r5 = r * 4 + r / 2;
    g6 = g * 8 + g;
    b5 = b * 8 + b * 2 + b / 2;
    return PW'(r5 * 2048 + g6 * 32 + b5);
`else
    return p;
`endif
  endfunction

  // monitor: read order, occupancy bound, stall stability, pixel order
  always @(negedge clk) begin
    if (!rst && frame_active != 0) begin
      if (rd_en) begin
        if (first_rd_cyc < 0) first_rd_cyc = cyc - start_cyc;
        check_eq("rd_addr", 32'(addr), 32'(BASE + reads_issued));
        reads_issued++;
        check_eq("occupancy_le4", 32'((reads_issued - pix_cnt) <= 4), 32'd1);
      end
      if (prev_stall) begin
        check_eq("stall_valid", 32'(pix_valid), 32'd1);
        check_eq("stall_data", 32'(pix_data), 32'(prev_data));
      end
      if (pix_valid) begin
        if (first_valid_cyc < 0) first_valid_cyc = cyc - start_cyc;
        check_eq("pix_last", 32'(pix_last), 32'(pix_cnt == TOTAL - 1));
      end
      if (pix_valid && pix_ready) begin
        if (exp_q.size() == 0) check_eq("extra_pixel", 32'(pix_cnt), 32'(TOTAL));
        else check_eq("pix_data", 32'(pix_data), 32'(exp_q.pop_front()));
        if (pix_last) last_cnt++;
        pix_cnt++;
      end
      prev_stall = pix_valid && !pix_ready;
      prev_data = pix_data;
      if (frame_done) begin
        done_cyc = cyc - start_cyc;
        check_eq("done_busy", 32'(busy), 32'd0);
        check_eq("done_buf_req", 32'(buf_req), 32'd0);
        check_eq("done_pix_count", 32'(pix_cnt), 32'(TOTAL));
        check_eq("done_exp_left", 32'(exp_q.size()), 32'd0);
        check_eq("done_last_count", 32'(last_cnt), 32'd1);
        frame_active = 0;
      end
    end else if (!rst) begin
      check_eq("idle_frame_done", 32'(frame_done), 32'd0);
    end
  end

  // pix_ready driver
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: pix_ready = 1'b1;
        1: pix_ready = ~pix_ready;
        2: pix_ready = 1'b0;
        default: pix_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    check_eq({tag, "_buf_req"}, 32'(buf_req), 32'd0);
    check_eq({tag, "_rd_en"}, 32'(rd_en), 32'd0);
    check_eq({tag, "_addr"}, 32'(addr), 32'd0);
    check_eq({tag, "_pix_valid"}, 32'(pix_valid), 32'd0);
    check_eq({tag, "_pix_last"}, 32'(pix_last), 32'd0);
    check_eq({tag, "_pix_data"}, 32'(pix_data), 32'd0);
    check_eq({tag, "_state"}, 32'(dbg_state), 32'd0);
  endtask

  // driver: fill RAM, build expected frame, pulse start, check cycle 1
  task automatic begin_frame(input int random_fill);
    for (int a = 0; a < LEN; a++)
      ram[a] = (random_fill != 0) ? WIDTH'($urandom_range(0, 255)) : WIDTH'(a % 256);
    if (random_fill == 2) begin
      ram[BASE] = 8'hE3;
      ram[BASE + 1] = 8'h1C;
    end
    exp_q.delete();
    for (int i = 0; i < TOTAL; i++) exp_q.push_back(expand(ram[BASE + i]));
    @(posedge clk);
    #1;
    start = 1'b1;
    start_cyc = cyc;
    pix_cnt = 0;
    reads_issued = 0;
    first_rd_cyc = -1;
    first_valid_cyc = -1;
    done_cyc = -1;
    last_cnt = 0;
    prev_stall = 1'b0;
    frame_active = 1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check_eq("c1_busy", 32'(busy), 32'd1);
    check_eq("c1_buf_req", 32'(buf_req), 32'd1);
    check_eq("c1_rd_en", 32'(rd_en), 32'd1);
    check_eq("c1_addr", 32'(addr), 32'(BASE));
  endtask

  task automatic wait_done();
    int n = 0;
    while (frame_active != 0 && n < 40000) begin
      @(posedge clk);
      n++;
    end
    check_eq("frame_timeout", 32'(frame_active), 32'd0);
    frame_active = 0;
  endtask

  task automatic wait_pix_cnt(input int target);
    int n = 0;
    while (pix_cnt < target && n < 40000) begin
      @(posedge clk);
      n++;
    end
    check_eq("reach_pixel_timeout", 32'(pix_cnt >= target), 32'd1);
  endtask

  initial begin
    int n;
    ready_mode = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // frame 1: address pattern, ready held high, exact timing
    begin_frame(0);
    wait_done();
    check_eq("t_first_rd", 32'(first_rd_cyc), 32'd1);
    check_eq("t_first_valid", 32'(first_valid_cyc), 32'd4);
    check_eq("t_frame_done", 32'(done_cyc), 32'(4 + TOTAL));

    // frame 2: ready toggling, ignored start at pixel 500
    ready_mode = 1;
    begin_frame(1);
    wait_pix_cnt(500);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check_eq("busy_start_busy", 32'(busy), 32'd1);
    check_eq("busy_start_rd_en_ok", 32'(reads_issued > 500), 32'd1);
    wait_done();

    // frame 3: 20-cycle stall after first pixel, then random ready
    ready_mode = 2;
    begin_frame(1);
    n = 0;
    while (first_valid_cyc < 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    repeat (20) @(negedge clk);
    check_eq("stall_reads", 32'(reads_issued), 32'd4);
    check_eq("stall_rd_en", 32'(rd_en), 32'd0);
    check_eq("stall_pix_valid", 32'(pix_valid), 32'd1);
    ready_mode = 3;
    wait_done();

    // frame 4: reset at pixel 6000
    ready_mode = 0;
    begin_frame(1);
    wait_pix_cnt(6000);
    #1;
    rst = 1'b1;
    frame_active = 0;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // frame 5: fresh start after reset, colour expansion of known pixels
    ready_mode = 3;
    begin_frame(2);
    n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while (!(pix_valid && pix_cnt == 0) && n < 100);
    check_eq("rgb_e3", 32'(pix_data), EXP_E3);
    n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while (!(pix_valid && pix_cnt == 1) && n < 100);
    check_eq("rgb_1c", 32'(pix_data), EXP_1C);
    ready_mode = 0;
    wait_done();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
